vram_write_sequencer: RTL and testbench

- Parametrised successor to the fixed-sequence CPU VRAM writer used on the PPU bench. Accepts arbitrary VRAM write commands (address, data, byte enables) into an internal FIFO, then drains them onto the PPU's h2f_vram_* write port only during a write window opened by cpu_vram_wr_irq.
- Adds the following over the fixed writer: a per-window write budget, an address-range guard and a busy/done handshake.
- Sits between the HPS-side command source (or a bench driver) and ppu.

---
 rtl/vram_write_sequencer.sv | 174 +++++++++++++++++
 tb/tb_vram_write_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_sequencer.sv
// Queues VRAM write commands in a FIFO and drains them onto the PPU h2f_vram_* port
// during each cpu_vram_wr_irq window, with a per-window budget and an address guard.
module vram_write_sequencer #(
  parameter int unsigned       ADDR_W     = 13,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       DEPTH      = 16,
  parameter int unsigned       MAX_WRITES = 16,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 13'h1A27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [DATA_W/8-1:0]      cmd_byteena,
  input  logic                     cpu_vram_wr_irq,
  output logic [ADDR_W-1:0]        h2f_vram_wraddr,
  output logic                     h2f_vram_wren,
  output logic [DATA_W-1:0]        h2f_vram_wrdata,
  output logic [DATA_W/8-1:0]      h2f_vram_byteena,
  output logic                     cpu_wr_busy,
  output logic                     window_done,
  output logic                     range_err,
  input  logic                     range_err_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned      BE_W      = DATA_W / 8;
  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam int unsigned      LVL_W     = PTR_W + 1;
  localparam int unsigned      BUD_W     = (MAX_WRITES == 0) ? 1 : $clog2(MAX_WRITES + 1);
  localparam bit               UNLIMITED = (MAX_WRITES == 0);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [BUD_W-1:0] BUD_INIT  = BUD_W'(MAX_WRITES);
  localparam logic [BUD_W-1:0] BUD_ONE   = BUD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a <= ADDR_LIMIT);
  endfunction

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic              budget_ok;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;
  logic              head_legal;

  state_t            state;
  logic [BUD_W-1:0]  budget;

  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign level      = level_q;

  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign head_be    = be_mem[rd_ptr];
  assign head_legal = addr_legal(head_addr);

  assign budget_ok  = UNLIMITED || (budget != '0);
  assign pop        = (state == DRAIN) && !empty && budget_ok;
  // Closing the window on the final pop lines window_done up with the last wren.
  assign last_pop   = pop && ((level_q == LVL_ONE) || (!UNLIMITED && (budget == BUD_ONE)));

  // Command storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
      be_mem[wr_ptr]   <= cmd_byteena;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Window FSM with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      budget      <= '0;
      cpu_wr_busy <= 1'b0;
      window_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          window_done <= 1'b0;
          if (cpu_vram_wr_irq) begin
            state       <= DRAIN;
            budget      <= BUD_INIT;
            cpu_wr_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (pop) budget <= budget - BUD_ONE;
          if (!pop || last_pop) begin
            state       <= DONE;
            window_done <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          cpu_wr_busy <= 1'b0;
          window_done <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cpu_wr_busy <= 1'b0;
          window_done <= 1'b0;
        end
      endcase
    end
  end

  // Write port stage: popped entry lands here one cycle after the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h2f_vram_wraddr  <= '0;
      h2f_vram_wren    <= 1'b0;
      h2f_vram_wrdata  <= '0;
      h2f_vram_byteena <= '0;
      range_err        <= 1'b0;
    end else begin
      h2f_vram_wren <= 1'b0;
      if (pop && head_legal) begin
        h2f_vram_wren    <= 1'b1;
        h2f_vram_wraddr  <= head_addr;
        h2f_vram_wrdata  <= head_data;
        h2f_vram_byteena <= head_be;
      end
      if (pop && !head_legal) begin
        range_err <= 1'b1;
      end else if (range_err_clr) begin
        range_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_sequencer.sv
// Scoreboard bench for vram_write_sequencer: expected writes are queued at push time
// and matched against the h2f_vram_* port as wren pulses appear.
module tb_vram_write_sequencer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int ENT_W  = ADDR_W + DATA_W + BE_W;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [BE_W-1:0]   cmd_byteena;
  logic              cpu_vram_wr_irq;
  logic [ADDR_W-1:0] h2f_vram_wraddr;
  logic              h2f_vram_wren;
  logic [DATA_W-1:0] h2f_vram_wrdata;
  logic [BE_W-1:0]   h2f_vram_byteena;
  logic              cpu_wr_busy;
  logic              window_done;
  logic              range_err;
  logic              range_err_clr;
  logic [4:0]        level;

  vram_write_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .cmd_byteena      (cmd_byteena),
    .cpu_vram_wr_irq  (cpu_vram_wr_irq),
    .h2f_vram_wraddr  (h2f_vram_wraddr),
    .h2f_vram_wren    (h2f_vram_wren),
    .h2f_vram_wrdata  (h2f_vram_wrdata),
    .h2f_vram_byteena (h2f_vram_byteena),
    .cpu_wr_busy      (cpu_wr_busy),
    .window_done      (window_done),
    .range_err        (range_err),
    .range_err_clr    (range_err_clr),
    .level            (level)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ENT_W-1:0] exp_q [$];

  int wren_cnt;
  int busy_cnt;
  int done_cnt;
  int cyc = 0;
  int first_wren_cyc;
  int last_wren_cyc;
  int irq_cyc;
  bit done_with_wren;

  // Scoreboard monitor on the falling edge
  always @(negedge clk) begin
    logic [ENT_W-1:0] e;
    if (h2f_vram_wren) begin
      if (wren_cnt == 0) first_wren_cyc = cyc;
      last_wren_cyc = cyc;
      wren_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write got addr=%h data=%h be=%h, required no write",
                 h2f_vram_wraddr, h2f_vram_wrdata, h2f_vram_byteena);
      end else begin
        e = exp_q.pop_front();
        if ({h2f_vram_wraddr, h2f_vram_wrdata, h2f_vram_byteena} !== e) begin
          bad++;
          $display("FAIL sb_write got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                   h2f_vram_wraddr, h2f_vram_wrdata, h2f_vram_byteena,
                   e[ENT_W-1 -: ADDR_W], e[BE_W +: DATA_W], e[BE_W-1:0]);
        end
      end
    end
    if (cpu_wr_busy) busy_cnt++;
    if (window_done) begin
      done_cnt++;
      if (h2f_vram_wren) done_with_wren = 1'b1;
    end
    cyc++;
  end

  task automatic clr_counts();
    wren_cnt       = 0;
    busy_cnt       = 0;
    done_cnt       = 0;
    first_wren_cyc = -1;
    last_wren_cyc  = -1;
    done_with_wren = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [BE_W-1:0] be, input bit legal);
    bit ok;
    ok          = 1'b0;
    cmd_addr    = a;
    cmd_data    = d;
    cmd_byteena = be;
    cmd_valid   = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (ok) begin
      if (legal) exp_q.push_back({a, d, be});
    end else begin
      total++;
      bad++;
      $display("FAIL push_timeout addr=%h never accepted, required acceptance", a);
    end
  endtask

  task automatic pulse_irq();
    cpu_vram_wr_irq = 1'b1;
    @(posedge clk);
    #1;
    cpu_vram_wr_irq = 1'b0;
    irq_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = window_done;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout got no window_done, required one", tag);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_wren", int'(h2f_vram_wren), 0);
    chk("reset_wraddr", int'(h2f_vram_wraddr), 0);
    chk("reset_busy", int'(cpu_wr_busy), 0);
    chk("reset_done", int'(window_done), 0);
    chk("reset_range_err", int'(range_err), 0);
    chk("reset_level", int'(level), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_eight_writes();
    logic [ADDR_W-1:0] addrs [8];
    addrs = '{13'h0000, 13'h07FF, 13'h0800, 13'h17FF, 13'h1800, 13'h19FF, 13'h1A00, 13'h1A27};
    foreach (addrs[i]) push(addrs[i], 64'd12345, 8'hFF, 1'b1);
    chk("eight_level_full", int'(level), 8);
    clr_counts();
    pulse_irq();
    wait_done("eight");
    chk("eight_wren_cnt", wren_cnt, 8);
    chk("eight_first_latency", first_wren_cyc - irq_cyc, 1);
    chk("eight_consecutive", last_wren_cyc - first_wren_cyc, 7);
    chk("eight_done_cnt", done_cnt, 1);
    chk("eight_done_with_last_wren", int'(done_with_wren), 1);
    chk("eight_busy_cycles", busy_cnt, 9);
    chk("eight_level_empty", int'(level), 0);
    chk("eight_range_err", int'(range_err), 0);
  endtask

  task automatic test_fill_budget();
    for (int i = 0; i < 16; i++)
      push(ADDR_W'(16'h0100 + i), {$urandom, $urandom}, BE_W'(i * 17), 1'b1);
    chk("fill_level", int'(level), 16);
    chk("fill_ready_low", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_addr  = 13'h0555;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("fill_refused_level", int'(level), 16);
    clr_counts();
    fork
      pulse_irq();
      for (int i = 16; i < 20; i++)
        push(ADDR_W'(16'h0100 + i), {$urandom, $urandom}, BE_W'(i * 3), 1'b1);
    join
    wait_done("fill1");
    chk("fill_budget_writes", wren_cnt, 16);
    chk("fill_carry_level", int'(level), 4);
    clr_counts();
    pulse_irq();
    wait_done("fill2");
    chk("fill_second_writes", wren_cnt, 4);
    chk("fill_second_level", int'(level), 0);
  endtask

  task automatic test_out_of_range();
    range_err_clr = 1'b0;
    push(13'h0010, 64'hA5A5_0000_0000_0010, 8'h0F, 1'b1);
    push(13'h1A28, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0);
    push(13'h0011, 64'h5A5A_0000_0000_0011, 8'hF0, 1'b1);
    clr_counts();
    pulse_irq();
    wait_done("oor");
    chk("oor_wren_cnt", wren_cnt, 2);
    chk("oor_gap", last_wren_cyc - first_wren_cyc, 2);
    chk("oor_range_err_set", int'(range_err), 1);
    chk("oor_level", int'(level), 0);
    range_err_clr = 1'b1;
    @(posedge clk);
    #1;
    range_err_clr = 1'b0;
    chk("oor_range_err_clr", int'(range_err), 0);
  endtask

  task automatic test_empty_window();
    clr_counts();
    pulse_irq();
    wait_done("empty");
    chk("empty_busy_cycles", busy_cnt, 2);
    chk("empty_done_cnt", done_cnt, 1);
    chk("empty_wren_cnt", wren_cnt, 0);
  endtask

  task automatic test_irq_during_drain();
    for (int i = 0; i < 6; i++)
      push(ADDR_W'(16'h0200 + i), {$urandom, $urandom}, 8'hFF, 1'b1);
    clr_counts();
    pulse_irq();
    @(posedge clk);
    #1;
    cpu_vram_wr_irq = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_vram_wr_irq = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("irqdrain_done_cnt", done_cnt, 1);
    chk("irqdrain_wren_cnt", wren_cnt, 6);
    chk("irqdrain_busy_cycles", busy_cnt, 7);
  endtask

  task automatic test_reset_mid_drain();
    bit hit;
    for (int i = 0; i < 10; i++)
      push(ADDR_W'(16'h0300 + i), {$urandom, $urandom}, 8'hFF, 1'b1);
    clr_counts();
    pulse_irq();
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      #1;
      hit = (wren_cnt == 3);
    end
    chk("rstmid_third_write_seen", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wren", int'(h2f_vram_wren), 0);
    chk("rstmid_level", int'(level), 0);
    chk("rstmid_busy", int'(cpu_wr_busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clr_counts();
    pulse_irq();
    wait_done("rstmid");
    chk("rstmid_after_wren_cnt", wren_cnt, 0);
    chk("rstmid_after_done_cnt", done_cnt, 1);
  endtask

  initial begin
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    cmd_addr        = '0;
    cmd_data        = '0;
    cmd_byteena     = '0;
    cpu_vram_wr_irq = 1'b0;
    range_err_clr   = 1'b0;
    clr_counts();
    test_reset();
    test_eight_writes();
    test_fill_budget();
    test_out_of_range();
    test_empty_window();
    test_irq_during_drain();
    test_reset_mid_drain();
    chk("sb_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
